// File: rtl/xr_pkg.sv
// Shared arbiter definitions: FSM state encoding, default timeout and
// the saturating timeout-counter step used by the arbiter.
package xr_pkg;

  // Arbiter FSM states.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_e;

  // Default number of cycles a granted transfer may wait for ready.
  localparam int TIMEOUT_DEFAULT = 255;

  // Width of the timeout counter; TIMEOUT must fit in it.
  localparam int TMO_W = 8;

  // Increment the timeout counter, holding it at max instead of wrapping.
  function automatic logic [TMO_W-1:0] tmo_step(
    input logic [TMO_W-1:0] cnt,
    input logic [TMO_W-1:0] max
  );
    logic [TMO_W-1:0] nxt;
    nxt = cnt;
    if (cnt < max) begin
      nxt = cnt + 1'b1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/d_arb_rr_sel2.sv
// Two-way round-robin winner select. A lone requester wins; on a tie the
// master that was not served last wins.
module rr_sel2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       winner,
  output logic       any
);

  // Pick the winner from the request pair and the last-served master.
  always_comb begin
    any    = |req;
    winner = 1'b0;
    case (req)
      2'b01:   winner = 1'b0;
      2'b10:   winner = 1'b1;
      2'b11:   winner = ~last;
      default: winner = 1'b0;
    endcase
  end

endmodule

// File: rtl/d_arb.sv
// Two-master to one-slave memory arbiter. In IDLE the winning master is
// forwarded combinationally with zero added latency; a transfer that does
// not complete in its first cycle locks the grant (BUSY) until completion,
// request drop, or timeout. A timeout aborts the transfer by pulsing the
// master's pending ready together with its err line.
//
// Handshake: a master holds rd_req/wr_req (with addr/be/wr_data) stable
// until it sees the matching ready; a request completes in the cycle where
// the forwarded req and the downstream ready are both 1. Readies reach only
// the master forwarded in that cycle, and only while it is requesting.
module d_arb
  import xr_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int ADDR_LEN = 14,
  parameter int TIMEOUT  = TIMEOUT_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,

  // Master 0: CPU load/store unit
  input  logic [ADDR_LEN-1:0] m0_addr,
  input  logic                m0_rd_req,
  input  logic                m0_wr_req,
  input  logic [XLEN/8-1:0]   m0_be,
  input  logic [XLEN-1:0]     m0_wr_data,
  output logic                m0_rd_ready,
  output logic                m0_wr_ready,
  output logic                m0_err,
  output logic [XLEN-1:0]     m0_rd_data,

  // Master 1: debug / loader
  input  logic [ADDR_LEN-1:0] m1_addr,
  input  logic                m1_rd_req,
  input  logic                m1_wr_req,
  input  logic [XLEN/8-1:0]   m1_be,
  input  logic [XLEN-1:0]     m1_wr_data,
  output logic                m1_rd_ready,
  output logic                m1_wr_ready,
  output logic                m1_err,
  output logic [XLEN-1:0]     m1_rd_data,

  // Downstream slave
  output logic [ADDR_LEN-1:0] addr,
  output logic                rd_req,
  output logic                wr_req,
  output logic [XLEN/8-1:0]   be,
  output logic [XLEN-1:0]     wr_data,
  input  logic                rd_ready,
  input  logic                wr_ready,
  input  logic [XLEN-1:0]     rd_data,

  // Status
  output logic                busy
);

  localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT);

  arb_state_e       state;
  logic             grant;
  logic             last;
  logic [TMO_W-1:0] tmo_cnt;

  logic [1:0]          req;
  logic                winner;
  logic                any;
  logic                sel;
  logic                sel_active;
  logic                sel_rd;
  logic                sel_wr;
  logic [ADDR_LEN-1:0] sel_addr;
  logic [XLEN/8-1:0]   sel_be;
  logic [XLEN-1:0]     sel_wr_data;
  logic                fwd_cpl;
  logic                tmo_hit;
  logic                drive;
  logic                route_rd;
  logic                route_wr;
  logic                route_err;

  assign req[0] = m0_rd_req | m0_wr_req;
  assign req[1] = m1_rd_req | m1_wr_req;

  rr_sel2 u_rr_sel2 (
    .req    (req),
    .last   (last),
    .winner (winner),
    .any    (any)
  );

  // Choose which master is forwarded and gather its request fields.
  always_comb begin
    sel         = (state == ST_BUSY) ? grant : winner;
    sel_active  = sel ? req[1] : req[0];
    sel_rd      = sel ? m1_rd_req  : m0_rd_req;
    sel_wr      = sel ? m1_wr_req  : m0_wr_req;
    sel_addr    = sel ? m1_addr    : m0_addr;
    sel_be      = sel ? m1_be      : m0_be;
    sel_wr_data = sel ? m1_wr_data : m0_wr_data;
  end

  // Completion and timeout detection for the forwarded request.
  always_comb begin
    fwd_cpl = sel_active & ((sel_rd & rd_ready) | (sel_wr & wr_ready));
    tmo_hit = (state == ST_BUSY) & sel_active & ~fwd_cpl & (tmo_cnt == TMO_MAX);
    drive   = sel_active & ~tmo_hit & ~rst;
  end

  // Downstream request mux; fields are zero when nobody is forwarded.
  always_comb begin
    addr    = '0;
    be      = '0;
    wr_data = '0;
    rd_req  = drive & sel_rd;
    wr_req  = drive & sel_wr;
    if (sel_active) begin
      addr    = sel_addr;
      be      = sel_be;
      wr_data = sel_wr_data;
    end
  end

  // Return path: readies to the forwarded master, or abort pulses on timeout.
  always_comb begin
    route_rd  = 1'b0;
    route_wr  = 1'b0;
    route_err = 1'b0;
    if (sel_active && !rst) begin
      if (tmo_hit) begin
        route_rd  = sel_rd;
        route_wr  = sel_wr;
        route_err = 1'b1;
      end else begin
        route_rd  = rd_ready;
        route_wr  = wr_ready;
      end
    end
    m0_rd_ready = route_rd  & ~sel;
    m0_wr_ready = route_wr  & ~sel;
    m0_err      = route_err & ~sel;
    m1_rd_ready = route_rd  & sel;
    m1_wr_ready = route_wr  & sel;
    m1_err      = route_err & sel;
    m0_rd_data  = rd_data;
    m1_rd_data  = rd_data;
    busy        = (state == ST_BUSY) & ~rst;
  end

  // Arbiter FSM: grant lock, round-robin history and timeout counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      grant   <= 1'b0;
      last    <= 1'b1;
      tmo_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (any) begin
            if (fwd_cpl) begin
              last <= winner;
            end else begin
              state   <= ST_BUSY;
              grant   <= winner;
              tmo_cnt <= TMO_W'(1);
            end
          end
        end
        ST_BUSY: begin
          if (!sel_active) begin
            // Granted master withdrew: release without touching history.
            state   <= ST_IDLE;
            tmo_cnt <= '0;
          end else if (fwd_cpl || tmo_hit) begin
            state   <= ST_IDLE;
            last    <= grant;
            tmo_cnt <= '0;
          end else begin
            tmo_cnt <= tmo_step(tmo_cnt, TMO_MAX);
          end
        end
        default: begin
          state   <= ST_IDLE;
          tmo_cnt <= '0;
        end
      endcase
    end
  end

endmodule
